// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driven by a pixel clock-enable divider,
// with graceful start/stop, line/frame pulses and a completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 10,
    parameter int unsigned FC_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            pix_ce,
    output logic [CW-1:0]   h_cnt,
    output logic [CW-1:0]   v_cnt,
    output logic            valid,
    output logic            hsync,
    output logic            vsync,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_cnt,
    output logic            busy
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    // Region bounds carry one extra bit so a zero back porch cannot overflow CW.
    localparam logic [CW:0]      H_ACT_E  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]      HS_B     = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]      HS_E     = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]      V_ACT_E  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]      VS_B     = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]      VS_E     = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [CW-1:0]     r_h;
    logic [CW-1:0]     r_v;
    logic              r_valid;
    logic              r_hs;
    logic              r_vs;
    logic              r_ls;
    logic              r_fs;
    logic [FC_W-1:0]   r_fc;

    state_t            w_state_nxt;
    logic              w_run_nxt;
    logic              w_pix_ce;
    logic              w_h_end;
    logic              w_v_end;
    logic              w_frame_wrap;
    logic [CW-1:0]     w_h_nxt;
    logic [CW-1:0]     w_v_nxt;
    logic [DIV_W-1:0]  w_div_nxt;

    always_comb begin
        w_pix_ce     = (r_state != S_IDLE) && (r_div == DIV_LAST);
        w_h_end      = (r_h == H_LAST);
        w_v_end      = (r_v == V_LAST);
        w_frame_wrap = w_pix_ce && w_h_end && w_v_end;

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = en ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = en ? S_RUN : S_DRAIN;
            S_DRAIN: w_state_nxt = en ? S_RUN : (w_frame_wrap ? S_IDLE : S_DRAIN);
            default: w_state_nxt = S_IDLE;
        endcase
        w_run_nxt = (w_state_nxt != S_IDLE);

        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (!w_run_nxt) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_pix_ce) begin
            w_h_nxt = w_h_end ? '0 : r_h + 1'b1;
            if (w_h_end)
                w_v_nxt = w_v_end ? '0 : r_v + 1'b1;
        end

        // The entry cycle from IDLE always starts a fresh pixel period.
        if (!w_run_nxt || r_state == S_IDLE || r_div == DIV_LAST)
            w_div_nxt = '0;
        else
            w_div_nxt = r_div + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_valid <= 1'b0;
            r_hs    <= ~HSYNC_POL;
            r_vs    <= ~VSYNC_POL;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            // Decoded from next counter values so they align with h_cnt/v_cnt.
            r_valid <= w_run_nxt && ({1'b0, w_h_nxt} < H_ACT_E) && ({1'b0, w_v_nxt} < V_ACT_E);
            r_hs    <= (w_run_nxt && ({1'b0, w_h_nxt} >= HS_B) && ({1'b0, w_h_nxt} < HS_E))
                       ? HSYNC_POL : ~HSYNC_POL;
            r_vs    <= (w_run_nxt && ({1'b0, w_v_nxt} >= VS_B) && ({1'b0, w_v_nxt} < VS_E))
                       ? VSYNC_POL : ~VSYNC_POL;
            r_ls    <= w_run_nxt && ((r_state == S_IDLE) || (w_pix_ce && w_h_end));
            r_fs    <= w_run_nxt && ((r_state == S_IDLE) || w_frame_wrap);
            if (w_frame_wrap)
                r_fc <= r_fc + 1'b1;
        end
    end

    assign pix_ce      = w_pix_ce;
    assign h_cnt       = r_h;
    assign v_cnt       = r_v;
    assign valid       = r_valid;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fc;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a frame-position model predicts every
// cycle's outputs, a separate monitor pops and compares them.
module tb_vga_timing_gen;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int DIV = 2;
    localparam int CW = 10, FCW = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int PF = HT * VT * DIV;  // clocks per frame

    logic clk = 1'b0;
    logic rst, en;
    logic pix_ce, valid, hsync, vsync, line_start, frame_start, busy;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [FCW-1:0] frame_cnt;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .CW(CW), .FC_W(FCW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pix_ce),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .hsync(hsync), .vsync(vsync), .line_start(line_start),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
    );

    typedef struct {
        int pix, h, v, vld, hs, vs, ls, fs, fc, bsy;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;
    bit done = 1'b0;

    // Model: mode 0=idle,1=run,2=drain; p = clock index within the frame.
    int m_mode = 0;
    int m_p = 0;
    int m_fc = 0;

    function automatic int mh();
        return (m_p / DIV) % HT;
    endfunction

    function automatic int mv();
        return m_p / (DIV * HT);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int b;
        b     = (m_mode != 0) ? 1 : 0;
        e.bsy = b;
        e.h   = mh();
        e.v   = mv();
        e.pix = (b != 0 && (m_p % DIV) == DIV - 1) ? 1 : 0;
        e.vld = (b != 0 && e.h < HA && e.v < VA) ? 1 : 0;
        e.hs  = (b != 0 && e.h >= HA + HF && e.h < HA + HF + HS) ? 0 : 1;
        e.vs  = (b != 0 && e.v >= VA + VF && e.v < VA + VF + VS) ? 0 : 1;
        e.ls  = (b != 0 && (m_p % (DIV * HT)) == 0) ? 1 : 0;
        e.fs  = (b != 0 && m_p == 0) ? 1 : 0;
        e.fc  = m_fc;
        return e;
    endfunction

    task automatic model_edge(input bit r, input bit e);
        bit last;
        if (r) begin
            m_mode = 0; m_p = 0; m_fc = 0;
        end else if (m_mode == 0) begin
            if (e) begin m_mode = 1; m_p = 0; end
        end else begin
            last = (m_p == PF - 1);
            m_p  = last ? 0 : m_p + 1;
            if (last) m_fc = (m_fc + 1) % (1 << FCW);
            if (e) m_mode = 1;
            else if (m_mode == 2 && last) m_mode = 0;
            else m_mode = 2;
        end
    endtask

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        model_edge(r, e);
        q.push_back(expect_now());
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Steps with en=e until the model sits on the first clock of pixel (h,v).
    task automatic run_until(input int h, input int v, input bit e);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * PF; i++) begin
            if (m_mode != 0 && mh() == h && mv() == v && (m_p % DIV) == 0) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, e);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reach_pos: got not-reached expected (%0d,%0d)", h, v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty expected entry");
            end else begin
                e = q.pop_front();
                chk("pix_ce", int'(pix_ce), e.pix);
                chk("h_cnt", int'(h_cnt), e.h);
                chk("v_cnt", int'(v_cnt), e.v);
                chk("valid", int'(valid), e.vld);
                chk("hsync", int'(hsync), e.hs);
                chk("vsync", int'(vsync), e.vs);
                chk("line_start", int'(line_start), e.ls);
                chk("frame_start", int'(frame_start), e.fs);
                chk("frame_cnt", int'(frame_cnt), e.fc);
                chk("busy", int'(busy), e.bsy);
            end
        end
    end

    initial begin : stimulus
        int len;
        bit e;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        for (int i = 0; i < PF + 12; i++) step(1'b0, 1'b1);

        // Graceful stop from (2,1).
        run_until(2, 1, 1'b1);
        for (int i = 0; i < 2 * PF && m_mode != 0; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // Resume during drain.
        step(1'b0, 1'b1);
        run_until(2, 1, 1'b1);
        run_until(6, 3, 1'b0);
        for (int i = 0; i < PF + 10; i++) step(1'b0, 1'b1);

        // Reset mid-frame.
        run_until(3, 2, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Five frames to wrap the 2-bit frame counter.
        for (int i = 0; i < 5 * PF + 4; i++) step(1'b0, 1'b1);

        for (int c = 0; c < 40; c++) begin
            len = int'($urandom_range(1, 60));
            e   = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < len; i++) step(1'b0, e);
            if ($urandom_range(0, 9) == 0) step(1'b1, $urandom_range(0, 1) != 0);
        end

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that replaces the fixed 640x480 controller and its separate 25 MHz derived clock. It runs on the system clock and produces a pixel clock-enable from an internal divider. Porches, sync widths, sync polarities and divide ratio are all parameters. It adds a graceful start/stop state machine, frame/line pulses and a frame counter for downstream pixel generators and animation logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1)
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync
CW, 10, width of h_cnt/v_cnt (must hold H_TOTAL-1 and V_TOTAL-1)
FC_W, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run request
pix_ce  out  1  pixel clock-enable, one clk wide
h_cnt  out  CW  current pixel column
v_cnt  out  CW  current line
valid  out  1  current pixel is in the active area
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
line_start  out  1  one-clk pulse when h_cnt becomes 0
frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)
frame_cnt  out  FC_W  completed-frame count
busy  out  1  state != IDLE

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined likewise.
- Reset (rst=1 at a clk edge, takes priority over everything, including mid-frame):
  - state=IDLE, divider=0, h_cnt=0, v_cnt=0, frame_cnt=0.
  - pix_ce=0, valid=0, line_start=0, frame_start=0, busy=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Divider:
  - Counts 0..CLK_DIV-1 only while state is RUN or DRAIN; held at 0 in IDLE.
  - pix_ce=1 on the cycle divider==CLK_DIV-1.
  - If CLK_DIV=1, pix_ce=1 on every RUN/DRAIN cycle.
- Counters advance only on a pix_ce cycle. h_cnt wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments, and v_cnt wraps V_TOTAL-1 -> 0.
- States:
  - IDLE: counters held at 0. en=1 moves to RUN next clk, and frame_start and line_start pulse on that entry cycle.
  - RUN: en=0 moves to DRAIN. Scanning continues unchanged.
  - DRAIN: scanning continues. en=1 returns to RUN with no disturbance to counters or syncs. On the pix_ce cycle at (H_TOTAL-1, V_TOTAL-1), go to IDLE with counters 0. No frame_start is issued for that wrap; frame_cnt still increments.
- Output alignment:
  - valid, hsync, vsync and the pulses are registered from the next counter values, so they are coherent with h_cnt/v_cnt in the same clk cycle (zero skew).
  - valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE) && state != IDLE.
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync is defined the same way on v_cnt with the V parameters and VSYNC_POL.
  - Both syncs are inactive in IDLE.
- Pulses:
  - line_start is one clk wide, on the cycle h_cnt becomes 0 while running.
  - frame_start is one clk wide, on the cycle both counters become 0 while running.
- frame_cnt increments by 1 (mod 2^FC_W) at every v wrap and wraps silently.
- busy = state is RUN or DRAIN.
- Simultaneous rst and en: rst wins.

Test Plan:
Use test parameters H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), CLK_DIV=2, polarities 0.
- Reset: hold rst 3 clks with en=1 -> all outputs at reset values; hsync=vsync=1, busy=0.
- Start and scan:
  - en=1 from IDLE -> busy=1 and frame_start=1 next clk; pix_ce every 2nd clk.
  - h_cnt runs 0..7; valid=1 for h 0..3 on v 0..2; hsync=0 exactly at h 5..6.
  - line_start pulses each h wrap.
- Full frame:
  - 96 clks after start -> v_cnt wraps 5->0, frame_start pulses, frame_cnt=1.
  - vsync=0 exactly while v_cnt=4.
- Graceful stop:
  - drop en at (h=2,v=1) -> scan continues to (7,5), then IDLE with counters 0 and busy=0.
  - frame_cnt increments once; no frame_start.
- Resume during DRAIN: drop en at (2,1), re-raise at (6,3) -> no gap in counting; next frame starts normally with frame_start.
- Reset mid-frame and wrap:
  - rst at (3,2) -> next clk all outputs at reset values.
  - With FC_W=2, run 5 frames -> frame_cnt goes 1,2,3,0,1.
